// File: rtl/int_issue_queue_pkg.sv
// Shared widths, entry layout and the CDB wakeup rule for the integer issue queue.
package int_issue_queue_pkg;

    localparam int IQ_TAG_W  = 5;
    localparam int IQ_DATA_W = 32;
    localparam int IQ_OPC_W  = 4;

    typedef struct packed {
        logic                 valid;
        logic [IQ_OPC_W-1:0]  opcode;
        logic [IQ_TAG_W-1:0]  rs_tag;
        logic [IQ_DATA_W-1:0] rs_data;
        logic                 rs_valid;
        logic [IQ_TAG_W-1:0]  rt_tag;
        logic [IQ_DATA_W-1:0] rt_data;
        logic                 rt_valid;
        logic [IQ_TAG_W-1:0]  rd_tag;
    } iq_entry_t;

    // Rs and Rt are matched independently, so one broadcast can wake both operands.
    function automatic iq_entry_t iq_wake(input iq_entry_t e,
                                          input logic cdb_valid,
                                          input logic [IQ_TAG_W-1:0] cdb_tag,
                                          input logic [IQ_DATA_W-1:0] cdb_data);
        iq_entry_t r;
        r = e;
        if (cdb_valid && e.valid) begin
            if (!e.rs_valid && e.rs_tag == cdb_tag) begin
                r.rs_data  = cdb_data;
                r.rs_valid = 1'b1;
            end
            if (!e.rt_valid && e.rt_tag == cdb_tag) begin
                r.rt_data  = cdb_data;
                r.rt_valid = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int_issue_queue_slot.sv
// One queue entry: chooses between hold, shift-in from the slot above, or a new dispatch,
// then applies the current CDB broadcast to whatever it is about to store.
module int_issue_queue_slot
    import int_issue_queue_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 flush,
    input  logic                 load,
    input  iq_entry_t            load_entry,
    input  logic                 shift,
    input  iq_entry_t            shift_entry,
    input  logic                 cdb_valid,
    input  logic [IQ_TAG_W-1:0]  cdb_tag,
    input  logic [IQ_DATA_W-1:0] cdb_data,
    output iq_entry_t            entry
);

    iq_entry_t base;
    iq_entry_t next_entry;

    always_comb begin
        base = entry;
        if (load) begin
            base = load_entry;
        end else if (shift) begin
            base = shift_entry;
        end
        next_entry = iq_wake(base, cdb_valid, cdb_tag, cdb_data);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            entry <= '0;
        end else if (flush) begin
            entry <= '0;
        end else begin
            entry <= next_entry;
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation-station queue: compacting shift queue with CDB wakeup and
// oldest-ready-first issue to the integer ALU.
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = IQ_TAG_W,
    parameter int DATA_W = IQ_DATA_W,
    parameter int OPC_W  = IQ_OPC_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              Dispatch_En,
    input  logic [OPC_W-1:0]  Dispatch_Opcode,
    input  logic [TAG_W-1:0]  Dispatch_Rs_Tag,
    input  logic [DATA_W-1:0] Dispatch_Rs_Data,
    input  logic              Dispatch_Rs_Valid,
    input  logic [TAG_W-1:0]  Dispatch_Rt_Tag,
    input  logic [DATA_W-1:0] Dispatch_Rt_Data,
    input  logic              Dispatch_Rt_Valid,
    input  logic [TAG_W-1:0]  Dispatch_Rd_Tag,
    output logic              Queue_Full,
    input  logic [TAG_W-1:0]  CDB_Tag,
    input  logic [DATA_W-1:0] CDB_Data,
    input  logic              CDB_Valid,
    output logic              Ready_Int,
    input  logic              Issue_Int,
    output logic [OPC_W-1:0]  Issue_Opcode,
    output logic [DATA_W-1:0] Issue_Rs_Data,
    output logic [DATA_W-1:0] Issue_Rt_Data,
    output logic [TAG_W-1:0]  Issue_Rd_Tag
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wr_idx;
    iq_entry_t        entries [DEPTH];
    iq_entry_t        disp_entry;
    iq_entry_t        sel_entry;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] at_or_above_sel;
    logic             any_ready;
    logic             do_issue;
    logic             do_dispatch;

    // at_or_above_sel marks every slot from the oldest ready entry upward; those slots
    // shift down by one when an issue fires.
    always_comb begin
        any_ready       = 1'b0;
        sel_entry       = '0;
        ready_vec       = '0;
        at_or_above_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entries[i].valid & entries[i].rs_valid & entries[i].rt_valid;
            if (ready_vec[i] && !any_ready) begin
                sel_entry = entries[i];
            end
            any_ready          = any_ready | ready_vec[i];
            at_or_above_sel[i] = any_ready;
        end
    end

    assign Queue_Full  = (count == CNT_W'(DEPTH));
    assign Ready_Int   = any_ready;
    assign do_issue    = Issue_Int & any_ready;
    assign do_dispatch = Dispatch_En & ~Queue_Full;
    assign wr_idx      = count - CNT_W'(do_issue);

    assign Issue_Opcode  = sel_entry.opcode;
    assign Issue_Rs_Data = sel_entry.rs_data;
    assign Issue_Rt_Data = sel_entry.rt_data;
    assign Issue_Rd_Tag  = sel_entry.rd_tag;

    assign disp_entry = '{valid:    1'b1,
                          opcode:   Dispatch_Opcode,
                          rs_tag:   Dispatch_Rs_Tag,
                          rs_data:  Dispatch_Rs_Data,
                          rs_valid: Dispatch_Rs_Valid,
                          rt_tag:   Dispatch_Rt_Tag,
                          rt_data:  Dispatch_Rt_Data,
                          rt_valid: Dispatch_Rt_Valid,
                          rd_tag:   Dispatch_Rd_Tag};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count <= '0;
        end else if (Flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(do_dispatch) - CNT_W'(do_issue);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        iq_entry_t upper;
        if (i == DEPTH - 1) begin : g_top
            assign upper = '0;
        end else begin : g_mid
            assign upper = entries[i+1];
        end

        int_issue_queue_slot u_slot (
            .Clk         (Clk),
            .Rst         (Rst),
            .flush       (Flush),
            .load        (do_dispatch && (wr_idx == CNT_W'(i))),
            .load_entry  (disp_entry),
            .shift       (do_issue && at_or_above_sel[i]),
            .shift_entry (upper),
            .cdb_valid   (CDB_Valid),
            .cdb_tag     (CDB_Tag),
            .cdb_data    (CDB_Data),
            .entry       (entries[i])
        );
    end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer reservation-station queue: the queue-side end of the Ready/Issue handshake driven by the central issue unit.
- Accepts dispatched ALU ops, snoops the CDB to wake up pending source operands, and raises Ready_Int whenever at least one entry has both operands available.
- When the issue unit grants Issue_Int, presents the oldest ready entry to the integer ALU and removes it from the queue.
- One instance per integer pipe (Int0, Int1).

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 5, ROB/CDB tag width.
- DATA_W, 32, operand width.
- OPC_W, 4, ALU opcode width.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, active-low
- Flush  in  1  mispredict flush; clears all entries
- Dispatch_En  in  1  write a new entry this cycle
- Dispatch_Opcode  in  OPC_W  ALU opcode
- Dispatch_Rs_Tag  in  TAG_W  producer tag of Rs
- Dispatch_Rs_Data  in  DATA_W  Rs value
- Dispatch_Rs_Valid  in  1  Rs value present
- Dispatch_Rt_Tag  in  TAG_W  producer tag of Rt
- Dispatch_Rt_Data  in  DATA_W  Rt value
- Dispatch_Rt_Valid  in  1  Rt value present
- Dispatch_Rd_Tag  in  TAG_W  destination tag
- Queue_Full  out  1  no free entry
- CDB_Tag  in  TAG_W  broadcast tag
- CDB_Data  in  DATA_W  broadcast result
- CDB_Valid  in  1  broadcast valid
- Ready_Int  out  1  at least one entry is ready
- Issue_Int  in  1  grant from the issue unit
- Issue_Opcode  out  OPC_W  selected entry opcode
- Issue_Rs_Data  out  DATA_W  selected Rs value
- Issue_Rt_Data  out  DATA_W  selected Rt value
- Issue_Rd_Tag  out  TAG_W  selected destination tag

Behaviour:
- One clock (Clk); reset (Rst) is asynchronous and active-low.
- Reset state: all entry valid bits 0, count 0.
  - Queue_Full=0, Ready_Int=0.
  - Issue_* outputs are 0 whenever no entry is selected.
- Storage is a compacting shift queue: entry 0 is the oldest; valid entries always occupy indices 0..count-1.
- Entry ready = valid & Rs_Valid & Rt_Valid, computed from registered state only.
  - Ready_Int = OR of entry-ready bits.
  - Select = lowest-index ready entry.
  - Issue_* are combinational from the selected entry.
- Issue handshake:
  - The issue unit may assert Issue_Int in the same cycle it samples Ready_Int.
  - On a clock edge with Issue_Int=1 and Ready_Int=1, the selected entry is removed; entries above it shift down by one.
  - Issue_Int while Ready_Int=0 is ignored; no state change.
- Dispatch:
  - Accepted when Dispatch_En=1 and Queue_Full=0; written at index count (or count-1 if an issue occurs the same edge).
  - Dispatch_En while Queue_Full=1 is dropped silently; the dispatcher must stall on Queue_Full.
- Queue_Full = (count==DEPTH), registered state. Issue and dispatch on the same edge while full: the dispatch is still dropped.
- CDB wakeup, on each edge with CDB_Valid=1:
  - Every valid entry with an unready operand whose tag equals CDB_Tag captures CDB_Data and sets that operand's valid bit.
  - Rs and Rt are matched independently; both may wake on the same broadcast.
  - An entry woken at edge N is ready (Ready_Int) after edge N. No same-cycle bypass to Issue_*.
- Dispatch/CDB race: if a dispatched operand has Valid=0 and its tag equals CDB_Tag with CDB_Valid=1 in the same cycle, the entry is written with CDB_Data and Valid=1.
- Shifting entries also apply that cycle's CDB wakeup.
- Flush has priority over dispatch, issue and wakeup: the next state is empty.
- Reset mid-operation clears everything asynchronously; the first dispatch after deassertion goes to index 0.
- count width = clog2(DEPTH+1). Count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package: TAG_W, DATA_W, OPC_W constants and an iq_entry_t struct (valid, opcode, rs/rt tag/data/valid, rd_tag).
- Natural sub-module: iq_entry_slot — one entry register that handles CDB tag compare, operand capture and shift-in mux; instantiated DEPTH times.

Test Plan:
- Reset: hold Rst=0, then release → Ready_Int=0, Queue_Full=0, Issue_Rd_Tag=0.
- Dispatch a ready op (opc 3, Rs=0x10 valid, Rt=0x20 valid, Rd 5) → Ready_Int=1 next cycle with Issue_Rs_Data=0x10; assert Issue_Int → queue empty, Ready_Int=0 after the edge.
- Dispatch with Rs pending on tag 7; CDB tag 7 data 0xAB 2 cycles later → Ready_Int rises the cycle after the broadcast, Issue_Rs_Data=0xAB.
- Dispatch Rt pending on tag 9 while CDB broadcasts tag 9 data 0x55 in the same cycle → entry ready the next cycle, Issue_Rt_Data=0x55.
- Fill 4 entries (Rd 1..4, all ready) → Queue_Full=1; 5th dispatch dropped; grant 4 times → issued Rd order 1,2,3,4.
- Entry 0 pending, entry 1 ready → entry 1 issues first; then assert Flush with 2 entries present → empty, Ready_Int=0, Queue_Full=0.
